// File: rtl/wb_intercon.sv
`default_nettype none
// ============================================================================
//  Module      : wb_intercon
//  Description : Single-master, NSLV-slave Wishbone interconnect with address
//                decode, error termination of unmapped accesses and a
//                saturating error counter. The stall watchdog is compiled in
//                when WB_INTERCON_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_intercon #(
    parameter int                                NSLV     = 4,
    parameter int                                AW       = 16,
    parameter int                                DW       = 16,
    parameter int                                DEC_LSB  = 4,
    parameter logic [NSLV*(AW-DEC_LSB)-1:0]      SLV_BASE = {12'h403, 12'h402, 12'h401, 12'h400},
    parameter int                                TIMEOUT  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AW-1:0]        m_adr_i,
    input  logic [DW-1:0]        m_dat_i,
    input  logic                 m_we_i,
    input  logic                 m_cyc_i,
    input  logic                 m_stb_i,
    output logic [DW-1:0]        m_dat_o,
    output logic                 m_ack_o,
    output logic                 m_err_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic [NSLV-1:0]      s_stb_o,
    input  logic [NSLV*DW-1:0]   s_dat_i,
    input  logic [NSLV-1:0]      s_ack_i,
    output logic [7:0]           err_cnt_o
);

    localparam int         c_sel_w   = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int         c_base_w  = AW - DEC_LSB;
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_act  = 2'd1;
    localparam logic [1:0] c_st_err  = 2'd2;

    if (NSLV < 1 || NSLV > 8 || TIMEOUT < 2) begin : g_param_check
        $error("wb_intercon: NSLV must be 1..8 and TIMEOUT at least 2");
    end

    logic [1:0]          state_q, state_d;
    logic [c_sel_w-1:0]  sel_q, sel_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                w_hit;
    logic [c_sel_w-1:0]  w_hit_idx;
    logic                w_expire;
    logic [NSLV-1:0]     w_stb;
    logic                w_ack;
    logic                w_err;
    logic [DW-1:0]       w_dat;

`ifdef WB_INTERCON_TIMEOUT_EN
    localparam int c_tmr_w = $clog2(TIMEOUT);
    logic [c_tmr_w-1:0] timer_q, timer_d;

    // Expiry one count early so the err cycle lands TIMEOUT cycles after the strobe cycle
    assign w_expire = (timer_q == c_tmr_w'(TIMEOUT - 2));
`else
    assign w_expire = 1'b0;
`endif

    assign s_adr_o   = m_adr_i;
    assign s_dat_o   = m_dat_i;
    assign s_we_o    = m_we_i;
    assign s_cyc_o   = m_cyc_i;
    assign s_stb_o   = w_stb;
    assign m_ack_o   = w_ack;
    assign m_err_o   = w_err;
    assign m_dat_o   = w_dat;
    assign err_cnt_o = err_cnt_q;

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (m_adr_i[AW-1:DEC_LSB] == SLV_BASE[k*c_base_w +: c_base_w]) begin
                w_hit     = 1'b1;
                w_hit_idx = k[c_sel_w-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        err_cnt_d = err_cnt_q;
        w_stb     = '0;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        w_dat     = '0;
`ifdef WB_INTERCON_TIMEOUT_EN
        timer_d   = timer_q;
`endif
        case (state_q)
            c_st_idle: begin
                if (m_cyc_i && m_stb_i) begin
                    if (w_hit) begin
                        w_stb[w_hit_idx] = 1'b1;
                        sel_d            = w_hit_idx;
                        w_dat            = s_dat_i[int'(w_hit_idx)*DW +: DW];
                        w_ack            = s_ack_i[w_hit_idx];
                        if (!s_ack_i[w_hit_idx]) begin
                            state_d = c_st_act;
`ifdef WB_INTERCON_TIMEOUT_EN
                            timer_d = '0;
`endif
                        end
                    end else begin
                        state_d = c_st_err;
                    end
                end
            end
            c_st_act: begin
                w_dat = s_dat_i[int'(sel_q)*DW +: DW];
                if (!m_cyc_i) begin
                    state_d = c_st_idle;
                end else begin
                    w_stb[sel_q] = m_stb_i;
                    w_ack        = s_ack_i[sel_q];
                    if (s_ack_i[sel_q]) begin
                        state_d = c_st_idle;
                    end else if (w_expire) begin
                        state_d = c_st_err;
                    end else begin
`ifdef WB_INTERCON_TIMEOUT_EN
                        timer_d = timer_q + 1'b1;
`endif
                    end
                end
            end
            c_st_err: begin
                w_err   = 1'b1;
                state_d = c_st_idle;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: state_d = c_st_idle;
        endcase
        // Master-facing outputs are forced quiet for the whole reset window
        if (!rst_i) begin
            w_stb = '0;
            w_ack = 1'b0;
            w_err = 1'b0;
            w_dat = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= c_st_idle;
            sel_q     <= '0;
            err_cnt_q <= '0;
`ifdef WB_INTERCON_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            err_cnt_q <= err_cnt_d;
`ifdef WB_INTERCON_TIMEOUT_EN
            timer_q   <= timer_d;
`endif
        end
    end

endmodule
`default_nettype wire
